// File: rtl/uart_line_assembler_if.sv
// uart_line_assembler_if: UART byte streams and line read port of the line assembler
interface uart_line_assembler_if #(parameter int ADDR_W = 6);
    logic [7:0]      uart_rx_dat;
    logic            uart_rx_valid;
    logic            uart_tx_ready;
    logic [7:0]      uart_tx_dat;
    logic            uart_tx_send;
    logic [ADDR_W-1:0] line_rd_addr;
    logic [7:0]      line_rd_dat;
    logic [ADDR_W:0] line_len;
    logic            line_valid;
    logic            line_ack;
    logic            overflow;
    modport master (
        output uart_rx_dat, uart_rx_valid, uart_tx_ready, line_rd_addr, line_ack,
        input  uart_tx_dat, uart_tx_send, line_rd_dat, line_len, line_valid, overflow
    );
    modport slave (
        input  uart_rx_dat, uart_rx_valid, uart_tx_ready, line_rd_addr, line_ack,
        output uart_tx_dat, uart_tx_send, line_rd_dat, line_len, line_valid, overflow
    );
endinterface

// File: rtl/uart_line_assembler.sv
// uart_line_assembler: assembles UART bytes into an edited CR/LF-terminated line with echo
module uart_line_assembler #(
    parameter int MAX_LEN    = 64,
    parameter int ADDR_W     = 6,
    parameter int ECHO_EN    = 1,
    parameter int ECHO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    uart_line_assembler_if.slave bus
);
    localparam int FW = $clog2(ECHO_DEPTH);
    typedef enum logic {COLLECT, LINE_READY} state_t;
    state_t state;
    logic [7:0] buffer [MAX_LEN];
    logic [7:0] fifo [ECHO_DEPTH];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [FW:0] count;
    logic [ADDR_W:0] len, cur_len;
    logic [7:0] echo_dat, tx_dat, rd_dat;
    logic valid, overflow, tx_send;
    logic proc, is_term, is_bs, store, push, push_ok, pop;
    assign bus.uart_tx_dat = tx_dat;
    assign bus.uart_tx_send = tx_send;
    assign bus.line_rd_dat = rd_dat;
    assign bus.line_len = len;
    assign bus.line_valid = valid;
    assign bus.overflow = overflow;
    // Byte classification; an ACK in LINE_READY makes the same-cycle byte start a fresh line
    always_comb begin
        proc = bus.uart_rx_valid && (state == COLLECT || bus.line_ack);
        cur_len = state == COLLECT ? len : '0;
        is_term = bus.uart_rx_dat == 8'h0D || bus.uart_rx_dat == 8'h0A;
        is_bs = bus.uart_rx_dat == 8'h08 || bus.uart_rx_dat == 8'h7F;
        store = proc && !is_term && !is_bs && cur_len != (ADDR_W+1)'(MAX_LEN);
        push = ECHO_EN != 0 && proc && (store || ((is_term || is_bs) && cur_len != 0));
        echo_dat = is_bs ? 8'h08 : bus.uart_rx_dat;
        pop = count != 0 && bus.uart_tx_ready && !tx_send;
        push_ok = push && (count != (FW+1)'(ECHO_DEPTH) || pop);
    end
    // Line FSM: collect/edit bytes, then hold the finished line until acknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            len <= '0;
            valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == LINE_READY && bus.line_ack) begin
                state <= COLLECT;
                valid <= 1'b0;
                len <= '0;
                overflow <= 1'b0;
            end else if (state == LINE_READY && bus.uart_rx_valid) begin
                overflow <= 1'b1;
            end
            if (proc) begin
                if (is_term && cur_len != 0) begin
                    state <= LINE_READY;
                    valid <= 1'b1;
                end else if (is_bs && cur_len != 0) begin
                    len <= cur_len - (ADDR_W+1)'(1);
                end else if (store) begin
                    len <= cur_len + (ADDR_W+1)'(1);
                end else if (!is_term && !is_bs) begin
                    overflow <= 1'b1;
                end
            end
        end
    end
    // Line storage (not reset) and registered random-access read
    always_ff @(posedge clk) begin
        if (store) buffer[cur_len[ADDR_W-1:0]] <= bus.uart_rx_dat;
        rd_dat <= rst ? '0 : buffer[bus.line_rd_addr];
    end
    // Echo FIFO storage; a push into a full FIFO only lands when a pop frees a slot
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= echo_dat;
    end
    // Echo FIFO pointers and TX strobe; the send flag blocks back-to-back strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            tx_send <= 1'b0;
            tx_dat <= '0;
        end else begin
            tx_send <= pop;
            if (pop) begin
                tx_dat <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + FW'(1);
            end
            if (push_ok) wr_ptr <= wr_ptr + FW'(1);
            count <= count + (FW+1)'(push_ok) - (FW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_uart_line_assembler.sv
// tb_uart_line_assembler: scenario tasks plus randomized run against a queue-based line model
module tb_uart_line_assembler;
    localparam int AW = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_line_assembler_if #(.ADDR_W(AW)) bus();
    uart_line_assembler #(.MAX_LEN(64), .ADDR_W(AW), .ECHO_EN(1), .ECHO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_strobe = -1;
    int min_gap = 1000;
    logic [7:0] mline[$];
    logic [7:0] exp_echo[$];
    logic [7:0] got[$];
    bit ready = 0;
    bit ovf = 0;
    // Strobe monitor: records transmitted bytes and the tightest strobe spacing
    always @(negedge clk) begin
        cyc++;
        if (bus.uart_tx_send === 1'b1) begin
            got.push_back(bus.uart_tx_dat);
            if (last_strobe >= 0 && cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
            last_strobe = cyc;
        end
    end
    task automatic model_step(bit v, logic [7:0] b, bit ack);
        if (ready && ack) begin
            ready = 0;
            mline.delete();
            ovf = 0;
        end else if (ready) begin
            if (v) ovf = 1;
            return;
        end
        if (!v) return;
        if (b == 8'h0D || b == 8'h0A) begin
            if (mline.size() > 0) begin
                ready = 1;
                exp_echo.push_back(b);
            end
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mline.size() > 0) begin
                mline.delete(mline.size() - 1);
                exp_echo.push_back(8'h08);
            end
        end else if (mline.size() < 64) begin
            mline.push_back(b);
            exp_echo.push_back(b);
        end else begin
            ovf = 1;
        end
    endtask
    task automatic drive(bit v, logic [7:0] b, bit ack);
        bus.uart_rx_valid = v;
        bus.uart_rx_dat = b;
        bus.line_ack = ack;
        model_step(v, b, ack);
        @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b0;
        bus.line_ack = 1'b0;
    endtask
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic drain();
        for (int i = 0; i < 400 && got.size() < exp_echo.size(); i++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask
    function automatic int echo_diff();
        int n;
        n = got.size() < exp_echo.size() ? got.size() : exp_echo.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_echo[i]) return i;
        return got.size() == exp_echo.size() ? -1 : n;
    endfunction
    task automatic test_reset();
        bus.uart_rx_valid = 0;
        bus.uart_rx_dat = 0;
        bus.uart_tx_ready = 1;
        bus.line_rd_addr = 0;
        bus.line_ack = 0;
        rst = 1;
        idle(3);
        @(negedge clk);
        tests++; if (bus.uart_tx_dat !== 8'h00) begin fails++; $display("FAIL reset tx_dat: got %h want 00", bus.uart_tx_dat); end
        tests++; if (bus.uart_tx_send !== 1'b0) begin fails++; $display("FAIL reset tx_send: got %b want 0", bus.uart_tx_send); end
        tests++; if (bus.line_rd_dat !== 8'h00) begin fails++; $display("FAIL reset rd_dat: got %h want 00", bus.line_rd_dat); end
        tests++; if (bus.line_len !== 7'd0) begin fails++; $display("FAIL reset line_len: got %0d want 0", bus.line_len); end
        tests++; if (bus.line_valid !== 1'b0) begin fails++; $display("FAIL reset line_valid: got %b want 0", bus.line_valid); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset overflow: got %b want 0", bus.overflow); end
        rst = 0;
        idle(2);
    endtask
    task automatic test_basic_line();
        int d;
        bus.uart_tx_ready = 1;
        drive(1, 8'h41, 0); idle(3);
        drive(1, 8'h42, 0); idle(3);
        drive(1, 8'h0D, 0);
        @(negedge clk);
        tests++; if (bus.line_valid !== 1'b1) begin fails++; $display("FAIL basic line_valid: got %b want 1", bus.line_valid); end
        tests++; if (bus.line_len !== 7'(mline.size())) begin fails++; $display("FAIL basic line_len: got %0d want %0d", bus.line_len, mline.size()); end
        for (int i = 0; i < mline.size(); i++) begin
            bus.line_rd_addr = AW'(i);
            @(posedge clk);
            @(negedge clk);
            tests++; if (bus.line_rd_dat !== mline[i]) begin fails++; $display("FAIL basic read[%0d]: got %h want %h", i, bus.line_rd_dat, mline[i]); end
        end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL basic echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        tests++; if (min_gap < 2) begin fails++; $display("FAIL basic strobe spacing: got %0d want >=2", min_gap); end
        got.delete(); exp_echo.delete();
        drive(0, 8'h00, 1);
        @(negedge clk);
        tests++; if (bus.line_valid !== 1'b0 || bus.line_len !== 7'd0) begin fails++; $display("FAIL basic ack: got valid %b len %0d want 0 0", bus.line_valid, bus.line_len); end
    endtask
    task automatic test_backspace();
        int d;
        logic [7:0] seq [8];
        seq = '{8'h0D, 8'h0A, 8'h41, 8'h42, 8'h08, 8'h43, 8'h7F, 8'h0A};
        seq[6] = 8'h44;
        foreach (seq[k]) begin
            drive(1, seq[k], 0);
            idle(3);
        end
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd3 || mline.size() != 3) begin fails++; $display("FAIL bs line_len: got %0d want 3", bus.line_len); end
        tests++; if (bus.line_valid !== 1'b1) begin fails++; $display("FAIL bs line_valid: got %b want 1", bus.line_valid); end
        for (int i = 0; i < mline.size(); i++) begin
            bus.line_rd_addr = AW'(i);
            @(posedge clk);
            @(negedge clk);
            tests++; if (bus.line_rd_dat !== mline[i]) begin fails++; $display("FAIL bs read[%0d]: got %h want %h", i, bus.line_rd_dat, mline[i]); end
        end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL bs echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        got.delete(); exp_echo.delete();
        drive(0, 8'h00, 1);
        drive(1, 8'h41, 0); idle(3);
        drive(1, 8'h42, 0); idle(3);
        drive(1, 8'h7F, 0); idle(3);
        drive(1, 8'h7F, 0); idle(3);
        drive(1, 8'h7F, 0); idle(3);
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd0) begin fails++; $display("FAIL bs del to empty: got %0d want 0", bus.line_len); end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL bs del echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        got.delete(); exp_echo.delete();
    endtask
    task automatic test_overflow();
        int d;
        for (int i = 0; i < 65; i++) begin
            drive(1, 8'h30 + 8'(i % 64), 0);
            idle(2);
        end
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd64) begin fails++; $display("FAIL ovf line_len: got %0d want 64", bus.line_len); end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf overflow: got %b want 1", bus.overflow); end
        drive(1, 8'h0D, 0);
        @(negedge clk);
        tests++; if (bus.line_valid !== 1'b1) begin fails++; $display("FAIL ovf line_valid: got %b want 1", bus.line_valid); end
        bus.line_rd_addr = AW'(63);
        @(posedge clk);
        @(negedge clk);
        tests++; if (bus.line_rd_dat !== mline[63]) begin fails++; $display("FAIL ovf read[63]: got %h want %h", bus.line_rd_dat, mline[63]); end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL ovf echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        got.delete(); exp_echo.delete();
        drive(0, 8'h00, 1);
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd0 || bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf ack: got len %0d overflow %b want 0 0", bus.line_len, bus.overflow); end
    endtask
    task automatic test_ack_same_cycle();
        int d;
        drive(1, 8'h58, 0); idle(3);
        drive(1, 8'h59, 0); idle(3);
        drive(1, 8'h0A, 0); idle(3);
        drive(1, 8'h58, 0); idle(3);
        @(negedge clk);
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ackrx dropped overflow: got %b want 1", bus.overflow); end
        tests++; if (bus.line_len !== 7'd2) begin fails++; $display("FAIL ackrx frozen len: got %0d want 2", bus.line_len); end
        drive(1, 8'h5A, 1);
        @(negedge clk);
        tests++; if (bus.line_valid !== 1'b0) begin fails++; $display("FAIL ackrx line_valid: got %b want 0", bus.line_valid); end
        tests++; if (bus.line_len !== 7'd1) begin fails++; $display("FAIL ackrx line_len: got %0d want 1", bus.line_len); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ackrx overflow: got %b want 0", bus.overflow); end
        bus.line_rd_addr = 0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (bus.line_rd_dat !== 8'h5A) begin fails++; $display("FAIL ackrx read[0]: got %h want 5a", bus.line_rd_dat); end
        drive(0, 8'h00, 1);
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd1) begin fails++; $display("FAIL ackrx ack in collect: got len %0d want 1", bus.line_len); end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL ackrx echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        got.delete(); exp_echo.delete();
        drive(1, 8'h0D, 0);
        drive(0, 8'h00, 1);
        drain();
        got.delete(); exp_echo.delete();
    endtask
    task automatic test_echo_fifo_full();
        int d;
        bus.uart_tx_ready = 0;
        min_gap = 1000;
        last_strobe = -1;
        for (int i = 0; i < 6; i++) drive(1, 8'h61 + 8'(i), 0);
        idle(5);
        while (exp_echo.size() > 4) exp_echo.delete(exp_echo.size() - 1);
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd6) begin fails++; $display("FAIL fifo line_len: got %0d want 6", bus.line_len); end
        tests++; if (got.size() != 0) begin fails++; $display("FAIL fifo strobe while not ready: got %0d want 0", got.size()); end
        bus.uart_tx_ready = 1;
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL fifo echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        tests++; if (min_gap < 2) begin fails++; $display("FAIL fifo strobe spacing: got %0d want >=2", min_gap); end
        got.delete(); exp_echo.delete();
        drive(1, 8'h0D, 0);
        drive(0, 8'h00, 1);
        drain();
        got.delete(); exp_echo.delete();
    endtask
    task automatic test_reset_mid_line();
        bus.uart_tx_ready = 0;
        drive(1, 8'h61, 0);
        drive(1, 8'h62, 0);
        drive(1, 8'h63, 0);
        bus.uart_tx_ready = 1;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        got.delete();
        @(negedge clk);
        tests++; if (bus.line_len !== 7'd0) begin fails++; $display("FAIL rstmid line_len: got %0d want 0", bus.line_len); end
        tests++; if (bus.line_valid !== 1'b0) begin fails++; $display("FAIL rstmid line_valid: got %b want 0", bus.line_valid); end
        tests++; if (bus.uart_tx_send !== 1'b0) begin fails++; $display("FAIL rstmid tx_send: got %b want 0", bus.uart_tx_send); end
        rst = 0;
        mline.delete(); exp_echo.delete();
        ready = 0; ovf = 0;
        idle(20);
        tests++; if (got.size() != 0) begin fails++; $display("FAIL rstmid strobes after reset: got %0d want 0", got.size()); end
        got.delete();
    endtask
    task automatic test_random();
        int d, r;
        logic [7:0] b;
        bus.uart_tx_ready = 1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            b = r == 0 ? 8'h0D : r == 1 ? 8'h0A : r == 2 ? 8'h08 : r == 3 ? 8'h7F : 8'h20 + 8'($urandom_range(0, 94));
            if (ready) begin
                r = $urandom_range(0, 3);
                if (r < 2) drive(0, 8'h00, 1);
                else if (r == 2) drive(1, b, 1);
                else drive(1, b, 0);
            end else begin
                drive(1, b, $urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            tests++; if (bus.line_len !== 7'(mline.size())) begin fails++; $display("FAIL random line_len step %0d: got %0d want %0d", n, bus.line_len, mline.size()); end
            tests++; if (bus.line_valid !== ready) begin fails++; $display("FAIL random line_valid step %0d: got %b want %b", n, bus.line_valid, ready); end
            tests++; if (bus.overflow !== ovf) begin fails++; $display("FAIL random overflow step %0d: got %b want %b", n, bus.overflow, ovf); end
            idle($urandom_range(1, 4));
        end
        for (int i = 0; i < mline.size(); i++) begin
            bus.line_rd_addr = AW'(i);
            @(posedge clk);
            @(negedge clk);
            tests++; if (bus.line_rd_dat !== mline[i]) begin fails++; $display("FAIL random read[%0d]: got %h want %h", i, bus.line_rd_dat, mline[i]); end
        end
        drain();
        d = echo_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL random echo: got %0d strobes want %0d, first diff at %0d", got.size(), exp_echo.size(), d); end
        got.delete(); exp_echo.delete();
    endtask
    initial begin
        test_reset();
        test_basic_line();
        test_backspace();
        test_overflow();
        test_ack_same_cycle();
        test_echo_fifo_full();
        test_reset_mid_line();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_line_assembler.md
Name: uart_line_assembler

Overview:
- Sits directly downstream of UART_controller. Consumes its received-byte stream (UART_RX_DAT/UART_RX_VALID) and assembles bytes into a line buffer terminated by CR/LF.
- Applies backspace editing and echoes accepted characters back through the controller's transmit handshake (UART_TX_DAT/UART_TX_SEND/UART_TX_READY).
- Presents a completed line to the consumer (command parser / program loader) through a random-access read port with valid/ack handshake.

Parameters:
- MAX_LEN, 64, line buffer capacity in bytes (power of 2).
- ADDR_W, 6, log2(MAX_LEN); width of read address.
- ECHO_EN, 1, 1 = echo accepted bytes to TX, 0 = no echo (UART_TX_SEND held 0).
- ECHO_DEPTH, 4, echo FIFO depth (power of 2).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- UART_RX_DAT  in  8  received byte, valid when UART_RX_VALID=1.
- UART_RX_VALID  in  1  one-cycle pulse per received byte.
- UART_TX_READY  in  1  transmitter idle, can accept a byte.
- UART_TX_DAT  out  8  byte to transmit.
- UART_TX_SEND  out  1  one-cycle send strobe.
- LINE_RD_ADDR  in  ADDR_W  read address into line buffer.
- LINE_RD_DAT  out  8  buffer[LINE_RD_ADDR], registered, 1-cycle latency.
- LINE_LEN  out  ADDR_W+1  current byte count (0..MAX_LEN).
- LINE_VALID  out  1  completed line available.
- LINE_ACK  in  1  one-cycle pulse: consumer done, release line.
- OVERFLOW  out  1  sticky: byte dropped due to full buffer or line pending.

Behaviour:
- Reset values: UART_TX_DAT=0, UART_TX_SEND=0, LINE_RD_DAT=0, LINE_LEN=0, LINE_VALID=0, OVERFLOW=0. State=COLLECT, echo FIFO empty. Buffer contents are not reset.
- States: COLLECT, LINE_READY.
- COLLECT, on UART_RX_VALID, classify byte b:
  - b=0x0D or 0x0A, LINE_LEN>0: go LINE_READY, LINE_VALID=1 next cycle. Terminator is not stored; b is echoed.
  - b=0x0D or 0x0A, LINE_LEN=0: ignored, no echo. CRLF pairs therefore never create empty lines.
  - b=0x08 or 0x7F, LINE_LEN>0: LINE_LEN-1, echo 0x08.
  - b=0x08 or 0x7F, LINE_LEN=0: ignored, no echo.
  - Any other b, LINE_LEN<MAX_LEN: buffer[LINE_LEN]<=b, LINE_LEN+1, echo b.
  - Any other b, LINE_LEN=MAX_LEN: dropped, OVERFLOW<=1, no echo.
- LINE_READY:
  - Every UART_RX_VALID is dropped and sets OVERFLOW.
  - Buffer and LINE_LEN are frozen.
  - LINE_ACK: LINE_VALID<=0, LINE_LEN<=0, OVERFLOW<=0, state<=COLLECT.
- LINE_ACK while in COLLECT: ignored.
- Same cycle LINE_ACK and UART_RX_VALID in LINE_READY: ACK processed, and the byte is processed as the first byte of the new line (stored at index 0, LINE_LEN=1, echoed). OVERFLOW ends 0.
- Echo FIFO:
  - Push on each echo event listed above.
  - If full, the echo byte is dropped; line storage is unaffected and OVERFLOW is not set.
  - Pop when FIFO non-empty and UART_TX_READY=1 and UART_TX_SEND=0 in the current cycle. Next cycle: UART_TX_SEND=1 for exactly one cycle, UART_TX_DAT=popped byte, held until the next send.
  - Minimum 2 cycles between strobes, so the controller can drop READY.
  - Simultaneous push and pop: both occur, count unchanged. Push into a full FIFO coincident with a pop succeeds.
  - ECHO_EN=0: FIFO never pushed.
- LINE_RD_DAT <= buffer[LINE_RD_ADDR] every cycle, in any state. Addresses ≥LINE_LEN return stale data.
- Reset mid-line or mid-echo: line discarded, echo FIFO flushed, any in-progress strobe cancelled (UART_TX_SEND=0 the cycle after RST).
- Latency: byte accepted → LINE_LEN updated next cycle. Echo strobe no earlier than 2 cycles after UART_RX_VALID.

Test Plan:
- RX "AB", 0x0D, TX_READY=1 → LINE_VALID=1, LINE_LEN=2. Read addr 0/1 → 0x41/0x42 one cycle later. TX strobes 0x41, 0x42, 0x0D in order.
- RX "AB", 0x08, "C", 0x0A → LINE_LEN=2, buffer "AC". Echo 0x41, 0x42, 0x08, 0x43, 0x0A. Leading 0x0D/0x0A before "A" produce nothing.
- RX 65 printable bytes (MAX_LEN=64) → LINE_LEN=64, OVERFLOW=1 after 65th. Then 0x0D → LINE_VALID=1. LINE_ACK → LINE_LEN=0, OVERFLOW=0.
- LINE_READY with "X" received → dropped, OVERFLOW=1. LINE_ACK coincident with RX 0x5A → LINE_VALID=0, LINE_LEN=1, buffer[0]=0x5A, 0x5A echoed.
- TX_READY held 0, RX 6 bytes "abcdef" → FIFO holds 4, 2 echoes dropped. TX_READY=1 → exactly 4 strobes (a,b,c,d), spaced ≥2 cycles. LINE_LEN=6.
- Mid-line ("abc") with echo pending, pulse RST → next cycle LINE_LEN=0, LINE_VALID=0, UART_TX_SEND=0, no further strobes.
